mem_access: RTL

Data-memory access unit for the MEM stage of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and `MEM_WB`. It decodes the load/store operation and runs a request/acknowledge transaction on the data bus, and it sign- or zero-extends load data into `MEM_data_MEM`. While a transaction is outstanding it raises `mem_stall`, which drives the `is_hold` of every upstream pipeline register and of `MEM_WB`.

---
 rtl/mem_access.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   MEM-stage data-memory access unit of the five-stage MIPS pipeline.
//   Decodes the load/store op, runs a req/ack transaction on the data bus,
//   extends load data into MEM_data_MEM and holds the pipeline while a
//   transaction is outstanding.
//
// Parameters
//   TIMEOUT        WAIT cycles without bus_ack before abort (1..255)
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   mem_op_MEM     [3:0]  op: 0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW
//   addr_MEM       [31:0] byte address
//   store_data_MEM [31:0] store operand
//   bus_req        transaction request (registered)
//   bus_we         1 = write, 0 = read (registered)
//   bus_addr       [31:0] word-aligned address (registered)
//   bus_wdata      [31:0] lane-replicated write data (registered)
//   bus_be         [3:0]  byte-lane enables (registered)
//   bus_rdata      [31:0] read data, valid with bus_ack
//   bus_ack        completion strobe
//   MEM_data_MEM   [31:0] extended load result (registered)
//   mem_stall      pipeline hold request (combinational)
//   addr_err       misaligned-access flag (combinational)
//   bus_err        one-cycle timeout pulse (registered)
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] store_data_MEM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] MEM_data_MEM,
    output logic        mem_stall,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    // Counter value seen in the last allowed WAIT cycle: the abort happens at
    // the edge where the count would reach TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  cnt_r;
    logic [3:0]  op_r;
    logic [1:0]  off_r;

    logic        is_load_s;
    logic        is_store_s;
    logic        aligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic        go_s;
    logic        ack_s;
    logic        timeout_s;

    // Sign/zero-extends the lane selected by the captured op and byte offset.
    function automatic logic [31:0] ext_load(input logic [3:0]  op,
                                             input logic [1:0]  off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {off, 3'b000});
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   ext_load = {{24{b[7]}}, b};
            OP_LBU:  ext_load = {24'd0, b};
            OP_LH:   ext_load = {{16{h[15]}}, h};
            OP_LHU:  ext_load = {16'd0, h};
            OP_LW:   ext_load = rd;
            default: ext_load = 32'd0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op >= OP_LB) && (op <= OP_LW);
    endfunction

    // Op decode: class, alignment, lane enables and replicated store data.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        aligned_s  = 1'b1;
        be_s       = 4'b0000;
        wdata_s    = 32'd0;
        case (mem_op_MEM)
            OP_LB, OP_LBU: begin
                is_load_s = 1'b1;
                be_s      = 4'b0001 << addr_MEM[1:0];
            end
            OP_LH, OP_LHU: begin
                is_load_s = 1'b1;
                aligned_s = ~addr_MEM[0];
                be_s      = addr_MEM[1] ? 4'b1100 : 4'b0011;
            end
            OP_LW: begin
                is_load_s = 1'b1;
                aligned_s = (addr_MEM[1:0] == 2'b00);
                be_s      = 4'b1111;
            end
            OP_SB: begin
                is_store_s = 1'b1;
                be_s       = 4'b0001 << addr_MEM[1:0];
                wdata_s    = {4{store_data_MEM[7:0]}};
            end
            OP_SH: begin
                is_store_s = 1'b1;
                aligned_s  = ~addr_MEM[0];
                be_s       = addr_MEM[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{store_data_MEM[15:0]}};
            end
            OP_SW: begin
                is_store_s = 1'b1;
                aligned_s  = (addr_MEM[1:0] == 2'b00);
                be_s       = 4'b1111;
                wdata_s    = store_data_MEM;
            end
            default: begin
                is_load_s  = 1'b0;
                is_store_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; ack takes priority over the timeout.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((is_load_s || is_store_s) && aligned_s) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_ack || (cnt_r == TO_LAST)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: stall/error flags and datapath control strobes.
    always_comb begin
        go_s      = 1'b0;
        ack_s     = 1'b0;
        timeout_s = 1'b0;
        mem_stall = 1'b0;
        addr_err  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                go_s      = (is_load_s || is_store_s) && aligned_s;
                mem_stall = ~rst & go_s;
                addr_err  = ~rst & (is_load_s || is_store_s) & ~aligned_s;
            end
            ST_WAIT: begin
                ack_s     = bus_ack;
                timeout_s = ~bus_ack & (cnt_r == TO_LAST);
                mem_stall = ~rst;
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    // Bus request and attributes: latched at issue, held through WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'b0000;
            op_r      <= 4'd0;
            off_r     <= 2'd0;
        end else if (go_s) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store_s;
            bus_addr  <= {addr_MEM[31:2], 2'b00};
            bus_wdata <= wdata_s;
            bus_be    <= be_s;
            op_r      <= mem_op_MEM;
            off_r     <= addr_MEM[1:0];
        end else if (ack_s || timeout_s) begin
            bus_req   <= 1'b0;
        end
    end

    // WAIT-cycle counter, cleared at issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (go_s) begin
            cnt_r <= 8'd0;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    // Load result capture; zero on timeout, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MEM_data_MEM <= 32'd0;
        end else if (ack_s && op_is_load(op_r)) begin
            MEM_data_MEM <= ext_load(op_r, off_r, bus_rdata);
        end else if (timeout_s) begin
            MEM_data_MEM <= 32'd0;
        end
    end

    // Timeout pulse, coincident with DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_s;
        end
    end

endmodule
